instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 107 ++++++++++
 tb/tb_instr_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: streams a program into local memory while holding
// the core in reset, then serves combinational fetches. Define IMEM_FAULT_EN for fetch_fault.
module instr_mem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0400_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic                     reload,
  output logic                     core_hold,
  input  logic [31:0]              pc,
  output logic [31:0]              instruction,
  output logic [$clog2(DEPTH):0]   word_count
`ifdef IMEM_FAULT_EN
  ,
  output logic                     fetch_fault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX_C = CW'(DEPTH - 1);
  localparam logic [31:0]   NOP        = 32'h0000_0013;

  generate
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_mem_loader: DEPTH must be a power of two in 4..1024");
    end
  endgenerate

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            wr_en;
  logic [31:0]     idx;
  logic            fetch_ok;

  logic [31:0]     mem [DEPTH];

  assign load_ready = (state_q == LOAD) && (cnt_q < DEPTH_C);
  assign core_hold  = (state_q == LOAD);
  assign word_count = cnt_q;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (reload) begin
      // reload wins over a same-cycle accept: nothing is written or counted
      state_d = LOAD;
      cnt_d   = '0;
    end else if (accept) begin
      wr_en = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (load_last || cnt_q == LAST_IDX_C) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Contents survive reset and reload; word_count alone gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= load_data;
  end

  assign idx      = (pc - BASE_ADDR) >> 2;
  assign fetch_ok = (pc[1:0] == 2'b00) && (idx < {{(32-CW){1'b0}}, cnt_q});

  always_comb begin
    instruction = NOP;
    if (state_q == RUN && fetch_ok) instruction = mem[idx[AW-1:0]];
  end

`ifdef IMEM_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (reload)                          fault_d = 1'b0;
    else if (state_q == RUN && !fetch_ok) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized and directed checks of instr_mem_loader against a behavioural model.
module tb_instr_mem_loader;
  localparam int unsigned D    = 64;
  localparam logic [31:0] BASE = 32'h0400_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b0;
  logic        lv = 1'b0, ll = 1'b0, rl = 1'b0;
  logic [31:0] ld = '0, pc = BASE;
  logic        load_ready, core_hold;
  logic [31:0] instr;
  logic [6:0]  wc;
  logic        flt;

  logic        v4 = 1'b0, l4 = 1'b0, rl4 = 1'b0;
  logic [31:0] d4 = '0, pc4 = BASE;
  logic        ready4, hold4;
  logic [31:0] instr4;
  logic [2:0]  wc4;
  logic        flt4;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_last(ll),
    .load_ready(load_ready), .reload(rl), .core_hold(core_hold), .pc(pc),
    .instruction(instr), .word_count(wc)
`ifdef IMEM_FAULT_EN
    , .fetch_fault(flt)
`endif
  );

  instr_mem_loader #(.DEPTH(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst(rst), .load_valid(v4), .load_data(d4), .load_last(l4),
    .load_ready(ready4), .reload(rl4), .core_hold(hold4), .pc(pc4),
    .instruction(instr4), .word_count(wc4)
`ifdef IMEM_FAULT_EN
    , .fetch_fault(flt4)
`endif
  );

`ifndef IMEM_FAULT_EN
  assign flt  = 1'b0;
  assign flt4 = 1'b0;
`endif

  int nvec = 0, nerr = 0;

  // reference model: program image, words loaded, running flag, fault flag
  bit          m_run;
  int unsigned m_cnt;
  bit          m_flt;
  logic [31:0] m_mem [D];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    logic [31:0] i;
    i = (p - BASE) >> 2;
    if (m_run && p[1:0] == 2'b00 && i < m_cnt) return m_mem[i];
    return NOP;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_flt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit l, input bit r,
                            input logic [31:0] p);
    bit bad;
    bad = (p[1:0] != 2'b00) || (((p - BASE) >> 2) >= m_cnt);
    if (r) model_reset();
    else if (m_run) begin
      if (bad) m_flt = 1;
    end else if (v && m_cnt < D) begin
      m_mem[m_cnt] = d;
      m_cnt++;
      if (l || m_cnt == D) m_run = 1;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ready"}, {31'b0, load_ready}, {31'b0, !m_run && m_cnt < D});
    chk({tag, ".hold"},  {31'b0, core_hold},  {31'b0, !m_run});
    chk({tag, ".wc"},    {25'b0, wc},         m_cnt);
    chk({tag, ".instr"}, instr,               exp_instr(pc));
`ifdef IMEM_FAULT_EN
    chk({tag, ".fault"}, {31'b0, flt},        {31'b0, m_flt});
`endif
  endtask

  // one clock: drive at posedge+1, check mid-cycle, model advances on the edge
  task automatic cyc(input string tag, input bit v, input logic [31:0] d, input bit l,
                     input bit r, input logic [31:0] p);
    lv = v; ld = d; ll = l; rl = r; pc = p;
    #3;
    chk_all(tag);
    @(posedge clk);
    model_edge(v, d, l, r, p);
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    chk_all("rst");
    chk("rst4.ready", {31'b0, ready4}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // load test
    cyc("ld0", 1, 32'h00500093, 0, 0, BASE);
    cyc("ld1", 1, 32'h00A00113, 0, 0, BASE);
    cyc("ld2", 1, 32'h002081B3, 1, 0, BASE);
    chk("ld.wc", {25'b0, wc}, 32'd3);
    chk("ld.hold", {31'b0, core_hold}, 32'd0);
    cyc("ld.fetch", 0, 0, 0, 0, BASE + 32'h8);
    chk("ld.instr", instr, 32'h002081B3);

    // range test
    cyc("rg0", 0, 0, 0, 0, 32'h0400_000C);
    chk("rg0.instr", instr, NOP);
`ifdef IMEM_FAULT_EN
    chk("rg0.fault", {31'b0, flt}, 32'd1);
`endif
    cyc("rg1", 0, 0, 0, 0, 32'h0400_0002);
    chk("rg1.instr", instr, NOP);
    cyc("rg2", 0, 0, 0, 0, 32'h03FF_FFFC);
    chk("rg2.instr", instr, NOP);
    cyc("rg3", 0, 0, 0, 0, BASE);

    // reload test
    cyc("rl0", 0, 0, 0, 1, BASE);
    chk("rl.wc", {25'b0, wc}, 32'd0);
    chk("rl.hold", {31'b0, core_hold}, 32'd1);
    chk("rl.instr", instr, NOP);
    cyc("rl1", 1, 32'hDEAD_BEEF, 0, 1, BASE);
    chk("rl.coinc", {25'b0, wc}, 32'd0);

    // async reset mid-load
    cyc("rs0", 1, 32'h1111_1111, 0, 0, BASE);
    cyc("rs1", 1, 32'h2222_2222, 0, 0, BASE);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_all("rs.async");
    chk("rs.wc", {25'b0, wc}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("rs2", 1, 32'h3333_3333, 1, 0, BASE);
    chk("rs.hold", {31'b0, core_hold}, 32'd0);
    cyc("rs3", 0, 0, 0, 0, BASE);
    chk("rs.instr", instr, 32'h3333_3333);

    // backpressure: valid held high across 5 cycles, last on every beat
    cyc("bp.rl", 0, 0, 0, 1, BASE);
    for (int i = 0; i < 5; i++) cyc("bp", 1, 32'hA000_0000 + i, 1, 0, BASE);
    chk("bp.wc", {25'b0, wc}, 32'd1);
    chk("bp.hold", {31'b0, core_hold}, 32'd0);
    cyc("bp.fetch", 0, 0, 0, 0, BASE);
    chk("bp.instr", instr, 32'hA000_0000);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] p;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      p = BASE + 4 * $urandom_range(0, D + 2);
      else if (sel < 9) p = BASE + $urandom_range(0, 4 * D);
      else              p = $urandom;
      cyc("rnd", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 39) == 0), p);
    end

    // full test on the DEPTH=4 instance
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1; d4 = 32'hB000_0000 + i; l4 = 1'b0;
      @(posedge clk); #1;
      if (i == 2) chk("full.hold3", {31'b0, hold4}, 32'd1);
    end
    chk("full.wc", {29'b0, wc4}, 32'd4);
    chk("full.hold", {31'b0, hold4}, 32'd0);
    chk("full.ready", {31'b0, ready4}, 32'd0);
    d4 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("full.wc5", {29'b0, wc4}, 32'd4);
    pc4 = BASE + 32'hC;
    #1 chk("full.last", instr4, 32'hB000_0003);
    pc4 = BASE + 32'h10;
    #1 chk("full.oob", instr4, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
